// File: rtl/fire_control_pkg.sv
// Shared types and constants for the fire-control sequencer.
package fire_control_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FIRE     = 2'd1,
        ST_COOLDOWN = 2'd2,
        ST_RELOAD   = 2'd3
    } fc_state_e;

    localparam logic [3:0]  MODE_ATTACK       = 4'b0010;
    localparam int unsigned BURST_LEN_DEF     = 3;
    localparam int unsigned RELOAD_CYCLES_DEF = 8;
    localparam int unsigned TIMER_W           = 8;

endpackage

// File: rtl/fc_timer.sv
// Loadable down-counter shared by the cooldown and reload phases.
module fc_timer
    import fire_control_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic [TIMER_W-1:0] load_val_i,
    input  logic               dec_i,
    output logic               zero_o
);

    logic [TIMER_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/fire_control.sv
// Trigger/reload sequencer: turns raw pilot inputs into rate-limited fire
// pulses and reload strobes for the weapons stage.
module fire_control
    import fire_control_pkg::*;
#(
    parameter int unsigned AMMO_W        = 9,
    parameter int unsigned BURST_LEN     = BURST_LEN_DEF,
    parameter int unsigned RELOAD_CYCLES = RELOAD_CYCLES_DEF,
    parameter int unsigned SHOT_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        mode,
    input  logic              trigger,
    input  logic              burst_en,
    input  logic              reload_req,
    input  logic [7:0]        cooldown,
    input  logic [AMMO_W-1:0] magazine,
    input  logic [AMMO_W-1:0] ammo_count,
    output logic              fire,
    output logic              loading_ammo,
    output logic [AMMO_W-1:0] ammo_load,
    output logic              fault,
    output logic              busy,
    output logic [SHOT_W-1:0] shots
);

    localparam logic [TIMER_W-1:0] RELOAD_LOAD = TIMER_W'(RELOAD_CYCLES - 1);
    localparam logic [3:0]         BURST_M1    = 4'(BURST_LEN - 1);
    localparam logic [SHOT_W-1:0]  SHOT_ONE    = SHOT_W'(1);

    fc_state_e          state_q;
    logic               trig_q;
    logic [3:0]         burst_left_q;
    logic               reload_pend_q;
    logic               fire_q, loading_q, fault_q, busy_q;
    logic [AMMO_W-1:0]  ammo_load_q;
    logic [SHOT_W-1:0]  shots_q;

    logic               timer_load_d, timer_dec_d, timer_zero;
    logic [TIMER_W-1:0] timer_val_d;

    logic trig_rise, attack, ammo_ok;
    assign trig_rise = trigger & ~trig_q;
    assign attack    = (mode == MODE_ATTACK);
    assign ammo_ok   = (ammo_count != '0);

    // The timer is (re)loaded on the same edge the FSM enters COOLDOWN or RELOAD.
    always_comb begin
        timer_load_d = 1'b0;
        timer_val_d  = '0;
        timer_dec_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (reload_req || reload_pend_q) begin
                    timer_load_d = 1'b1;
                    timer_val_d  = RELOAD_LOAD;
                end
            end
            ST_FIRE: begin
                timer_load_d = 1'b1;
                timer_val_d  = cooldown;
            end
            ST_COOLDOWN: begin
                if (!timer_zero) begin
                    timer_dec_d = 1'b1;
                end else if (reload_pend_q) begin
                    timer_load_d = 1'b1;
                    timer_val_d  = RELOAD_LOAD;
                end
            end
            ST_RELOAD: begin
                timer_dec_d = !timer_zero;
            end
            default: ;
        endcase
    end

    fc_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (timer_load_d),
        .load_val_i (timer_val_d),
        .dec_i      (timer_dec_d),
        .zero_o     (timer_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            trig_q        <= 1'b0;
            burst_left_q  <= '0;
            reload_pend_q <= 1'b0;
            fire_q        <= 1'b0;
            loading_q     <= 1'b0;
            fault_q       <= 1'b0;
            busy_q        <= 1'b0;
            ammo_load_q   <= '0;
            shots_q       <= '0;
        end else begin
            trig_q      <= trigger;
            fire_q      <= (state_q == ST_FIRE);
            loading_q   <= (state_q == ST_RELOAD);
            ammo_load_q <= (state_q == ST_RELOAD) ? magazine : '0;
            busy_q      <= (state_q != ST_IDLE);
            fault_q     <= 1'b0;
            if ((state_q == ST_FIRE) && (shots_q != '1)) begin
                shots_q <= shots_q + SHOT_ONE;
            end

            case (state_q)
                ST_IDLE: begin
                    if (reload_req || reload_pend_q) begin
                        state_q       <= ST_RELOAD;
                        reload_pend_q <= 1'b0;
                    end else if (trig_rise) begin
                        if (attack && ammo_ok) begin
                            state_q      <= ST_FIRE;
                            burst_left_q <= burst_en ? BURST_M1 : '0;
                        end else begin
                            fault_q <= 1'b1;
                        end
                    end
                end
                ST_FIRE: begin
                    state_q <= ST_COOLDOWN;
                    if (reload_req) reload_pend_q <= 1'b1;
                end
                ST_COOLDOWN: begin
                    if (reload_req) reload_pend_q <= 1'b1;
                    if (timer_zero) begin
                        if (reload_pend_q) begin
                            state_q       <= ST_RELOAD;
                            reload_pend_q <= 1'b0;
                            burst_left_q  <= '0;
                        end else if ((burst_left_q != '0) && attack && ammo_ok) begin
                            state_q      <= ST_FIRE;
                            burst_left_q <= burst_left_q - 4'd1;
                        end else begin
                            state_q      <= ST_IDLE;
                            burst_left_q <= '0;
                        end
                    end
                end
                ST_RELOAD: begin
                    if (timer_zero) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign fire         = fire_q;
    assign loading_ammo = loading_q;
    assign ammo_load    = ammo_load_q;
    assign fault        = fault_q;
    assign busy         = busy_q;
    assign shots        = shots_q;

endmodule

// File: tb/tb_fire_control.sv
// Scoreboard bench for fire_control: expected fire/fault cycles are queued at
// stimulus time and matched against pulses captured from the DUT.
module tb_fire_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] mode;
    logic       trigger, burst_en, reload_req;
    logic [7:0] cooldown;
    logic [8:0] magazine, ammo_count;

    logic        fire, loading_ammo, fault, busy;
    logic [8:0]  ammo_load;
    logic [15:0] shots;
    logic        fire_s, loading_s, fault_s, busy_s;
    logic [8:0]  ammo_load_s;
    logic [3:0]  shots_s;

    fire_control dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .trigger(trigger),
        .burst_en(burst_en), .reload_req(reload_req), .cooldown(cooldown),
        .magazine(magazine), .ammo_count(ammo_count), .fire(fire),
        .loading_ammo(loading_ammo), .ammo_load(ammo_load), .fault(fault),
        .busy(busy), .shots(shots)
    );

    fire_control #(.SHOT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .mode(mode), .trigger(trigger),
        .burst_en(burst_en), .reload_req(reload_req), .cooldown(cooldown),
        .magazine(magazine), .ammo_count(ammo_count), .fire(fire_s),
        .loading_ammo(loading_s), .ammo_load(ammo_load_s), .fault(fault_s),
        .busy(busy_s), .shots(shots_s)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned fire_obs[$], fault_obs[$], fire_exp[$], fault_exp[$];
    int unsigned n_checks = 0, n_fail = 0;
    int unsigned shots_exp = 0;

    always @(negedge clk) begin
        if (fire === 1'b1)  fire_obs.push_back(cyc);
        if (fault === 1'b1) fault_obs.push_back(cyc);
    end

    task automatic test_reset();
        int unsigned t0;
        rst_n = 1'b1; mode = 4'b0000; trigger = 1'b0; burst_en = 1'b0;
        reload_req = 1'b0; cooldown = 8'd0; magazine = 9'd0; ammo_count = 9'd0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({fire, loading_ammo, fault, busy, ammo_load, shots, shots_s} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got fire=%b load=%b fault=%b busy=%b ammo_load=%0d shots=%0d expected all 0",
                     fire, loading_ammo, fault, busy, ammo_load, shots);
        end
        rst_n = 1'b1;
        @(negedge clk);
        magazine = 9'd300; reload_req = 1'b1; t0 = cyc;
        @(negedge clk);
        reload_req = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (loading_ammo !== 1'b1 || ammo_load !== 9'd300) begin
            n_fail++;
            $display("FAIL reset_reload_active: got load=%b ammo_load=%0d expected 1/300 at +%0d",
                     loading_ammo, ammo_load, cyc - t0);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({fire, loading_ammo, fault, busy, ammo_load, shots} !== '0) begin
            n_fail++;
            $display("FAIL reset_async: got load=%b ammo_load=%0d busy=%b expected all 0",
                     loading_ammo, ammo_load, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        shots_exp = 0;
        repeat (12) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || loading_ammo !== 1'b0 || shots !== 16'd0 || shots_s !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_release: got busy=%b load=%b shots=%0d expected 0/0/0",
                     busy, loading_ammo, shots);
        end
        fire_obs.delete(); fault_obs.delete();
    endtask

    task automatic test_single();
        int unsigned t0, e, o;
        mode = 4'b0010; ammo_count = 9'd5; burst_en = 1'b0; cooldown = 8'd3;
        @(negedge clk);
        trigger = 1'b1; t0 = cyc;
        fire_exp.push_back(t0 + 2); shots_exp++;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL single_busy_high: got %b expected 1", busy);
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL single_busy_low: got %b expected 0", busy);
        end
        repeat (12) @(negedge clk);
        trigger = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (shots !== 16'(shots_exp) || shots_s !== 4'(shots_exp > 15 ? 15 : shots_exp)) begin
            n_fail++; $display("FAIL single_shots: got %0d/%0d expected %0d", shots, shots_s, shots_exp);
        end
        n_checks++;
        if (fire_obs.size() != fire_exp.size() || fault_obs.size() != 0) begin
            n_fail++;
            $display("FAIL single_count: got fires=%0d faults=%0d expected %0d/0",
                     fire_obs.size(), fault_obs.size(), fire_exp.size());
        end
        while (fire_exp.size() != 0 && fire_obs.size() != 0) begin
            e = fire_exp.pop_front(); o = fire_obs.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++; $display("FAIL single_fire_cycle: got %0d expected %0d", o, e);
            end
        end
        fire_exp.delete(); fire_obs.delete(); fault_obs.delete();
    endtask

    task automatic test_burst();
        int unsigned t0, e, o;
        mode = 4'b0010; ammo_count = 9'd10; burst_en = 1'b1; cooldown = 8'd2;
        @(negedge clk);
        trigger = 1'b1; t0 = cyc;
        for (int i = 0; i < 3; i++) fire_exp.push_back(t0 + 2 + 4 * i);
        shots_exp += 3;
        repeat (3) @(negedge clk);
        trigger = 1'b0;
        repeat (17) @(negedge clk);
        n_checks++;
        if (shots !== 16'(shots_exp)) begin
            n_fail++; $display("FAIL burst_shots: got %0d expected %0d", shots, shots_exp);
        end
        n_checks++;
        if (fire_obs.size() != fire_exp.size() || fault_obs.size() != 0) begin
            n_fail++;
            $display("FAIL burst_count: got fires=%0d faults=%0d expected %0d/0",
                     fire_obs.size(), fault_obs.size(), fire_exp.size());
        end
        while (fire_exp.size() != 0 && fire_obs.size() != 0) begin
            e = fire_exp.pop_front(); o = fire_obs.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++; $display("FAIL burst_fire_cycle: got %0d expected %0d", o, e);
            end
        end
        fire_exp.delete(); fire_obs.delete(); fault_obs.delete();
    endtask

    task automatic test_illegal();
        int unsigned t0, e, o;
        burst_en = 1'b0; cooldown = 8'd1;
        mode = 4'b0001; ammo_count = 9'd5;
        @(negedge clk);
        trigger = 1'b1; t0 = cyc; fault_exp.push_back(t0 + 1);
        repeat (5) @(negedge clk);
        trigger = 1'b0;
        repeat (3) @(negedge clk);
        mode = 4'b0010; ammo_count = 9'd0;
        @(negedge clk);
        trigger = 1'b1; t0 = cyc; fault_exp.push_back(t0 + 1);
        repeat (5) @(negedge clk);
        trigger = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (fire_obs.size() != 0 || shots !== 16'(shots_exp)) begin
            n_fail++; $display("FAIL illegal_no_fire: got fires=%0d shots=%0d expected 0/%0d",
                               fire_obs.size(), shots, shots_exp);
        end
        n_checks++;
        if (fault_obs.size() != fault_exp.size()) begin
            n_fail++; $display("FAIL illegal_fault_count: got %0d expected %0d",
                               fault_obs.size(), fault_exp.size());
        end
        while (fault_exp.size() != 0 && fault_obs.size() != 0) begin
            e = fault_exp.pop_front(); o = fault_obs.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++; $display("FAIL illegal_fault_cycle: got %0d expected %0d", o, e);
            end
        end
        fault_exp.delete(); fault_obs.delete(); fire_obs.delete();
    endtask

    task automatic test_reload_burst();
        int unsigned t0, k, e, o, load_cnt, load_first;
        mode = 4'b0010; ammo_count = 9'd10; burst_en = 1'b1; cooldown = 8'd4; magazine = 9'd300;
        load_cnt = 0; load_first = 0;
        @(negedge clk);
        trigger = 1'b1; t0 = cyc;
        fire_exp.push_back(t0 + 2); shots_exp++;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            k = cyc - t0;
            if (loading_ammo === 1'b1) begin
                if (load_cnt == 0) load_first = k;
                load_cnt++;
            end
            n_checks++;
            if (ammo_load !== (loading_ammo === 1'b1 ? 9'd300 : 9'd0) || (fire & loading_ammo) !== 1'b0) begin
                n_fail++; $display("FAIL reload_ammo_load: got %0d load=%b fire=%b at +%0d",
                                   ammo_load, loading_ammo, fire, k);
            end
            if (k == 2) reload_req = 1'b1;
            if (k == 3) begin reload_req = 1'b0; trigger = 1'b0; end
            if (k == 10) trigger = 1'b1;
        end
        trigger = 1'b0;
        n_checks++;
        if (load_cnt != 8 || load_first != 8) begin
            n_fail++; $display("FAIL reload_window: got %0d cycles from +%0d expected 8 from +8",
                               load_cnt, load_first);
        end
        n_checks++;
        if (fire_obs.size() != fire_exp.size() || fault_obs.size() != 0) begin
            n_fail++;
            $display("FAIL reload_count: got fires=%0d faults=%0d expected %0d/0",
                     fire_obs.size(), fault_obs.size(), fire_exp.size());
        end
        while (fire_exp.size() != 0 && fire_obs.size() != 0) begin
            e = fire_exp.pop_front(); o = fire_obs.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++; $display("FAIL reload_fire_cycle: got %0d expected %0d", o, e);
            end
        end
        fire_exp.delete(); fire_obs.delete(); fault_obs.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_saturation();
        int unsigned t0, e, o;
        mode = 4'b0010; ammo_count = 9'd10; burst_en = 1'b1; cooldown = 8'd0;
        for (int b = 0; b < 7; b++) begin
            @(negedge clk);
            trigger = 1'b1; t0 = cyc;
            for (int i = 0; i < 3; i++) fire_exp.push_back(t0 + 2 + 2 * i);
            shots_exp += 3;
            @(negedge clk);
            trigger = 1'b0;
            repeat (9) @(negedge clk);
        end
        n_checks++;
        if (shots !== 16'(shots_exp)) begin
            n_fail++; $display("FAIL sat_shots_wide: got %0d expected %0d", shots, shots_exp);
        end
        n_checks++;
        if (shots_s !== 4'd15) begin
            n_fail++; $display("FAIL sat_shots_narrow: got %0d expected 15", shots_s);
        end
        n_checks++;
        if (fire_obs.size() != fire_exp.size()) begin
            n_fail++; $display("FAIL sat_fire_count: got %0d expected %0d",
                               fire_obs.size(), fire_exp.size());
        end
        while (fire_exp.size() != 0 && fire_obs.size() != 0) begin
            e = fire_exp.pop_front(); o = fire_obs.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++; $display("FAIL sat_fire_cycle: got %0d expected %0d", o, e);
            end
        end
        fire_exp.delete(); fire_obs.delete(); fault_obs.delete();
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_illegal();
        test_reload_burst();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fire_control.md
Name: fire_control

Overview:
- Upstream sequencer for the weapons stage: turns the pilot's raw trigger and reload request into clean, rate-limited fire pulses and reload strobes.
- Drives the weapons block's fire / loadingAmmo / ammo inputs and reads back its ammo count.
- Enforces attack-mode gating, single-shot vs burst firing, inter-shot cooldown and reload sequencing, and flags illegal trigger attempts.

Parameters:
- AMMO_W, 9, width of ammo count and magazine load value.
- BURST_LEN, 3, shots per burst when burst_en is set at the trigger edge (legal range 1..15).
- RELOAD_CYCLES, 8, cycles loadingAmmo is held per reload (≥1).
- SHOT_W, 16, width of the saturating shots-fired counter.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  4  ship mode; attack mode is 4'b0010.
- trigger  in  1  raw pilot trigger level.
- burst_en  in  1  burst select, sampled on the trigger rising edge.
- reload_req  in  1  reload request level.
- cooldown  in  8  idle cycles between shots, sampled when leaving FIRE.
- magazine  in  AMMO_W  ammo value to load on reload.
- ammo_count  in  AMMO_W  current ammo from weapons stage.
- fire  out  1  one-cycle fire pulse to weapons.
- loading_ammo  out  1  reload strobe to weapons.
- ammo_load  out  AMMO_W  load value to weapons, valid while loading_ammo=1, else 0.
- fault  out  1  one-cycle illegal-trigger pulse.
- busy  out  1  high in any state other than IDLE.
- shots  out  SHOT_W  total fire pulses issued, saturating.

Behaviour:
- Reset (rst_n=0, async): state=IDLE; fire, loading_ammo, fault, busy=0; ammo_load=0; shots=0; trig_q=0; burst_left=0; timer=0; reload_pend=0.
- Edge detect: trig_rise = trigger & ~trig_q; trig_q is registered every cycle. Trigger level-hold never refires.
- attack = (mode==4'b0010). ammo_ok = (ammo_count!=0).
- IDLE:
  - reload_req=1 (or reload_pend=1) → RELOAD; this has priority over the trigger.
  - Else trig_rise & attack & ammo_ok → FIRE, with burst_left = burst_en ? BURST_LEN-1 : 0.
  - Else trig_rise & (~attack | ~ammo_ok) → fault=1 for exactly one cycle; stay IDLE.
- FIRE: fire=1 for exactly this one cycle; shots+=1, saturating at all-ones; timer←cooldown; → COOLDOWN.
- COOLDOWN:
  - If timer!=0: timer-=1.
  - If timer==0 (exit):
    - reload_pend → RELOAD.
    - Else burst_left!=0 & attack & ammo_ok → FIRE, burst_left-=1.
    - Else → IDLE; burst_left←0.
  - Spacing between fire pulses within a burst is cooldown+2 cycles; cooldown=0 gives a pulse every 2 cycles.
- reload_req seen in FIRE or COOLDOWN sets reload_pend; the rest of the burst is aborted at cooldown exit. reload_pend clears on entering RELOAD.
- RELOAD:
  - loading_ammo=1 and ammo_load=magazine for RELOAD_CYCLES consecutive cycles, counted by the timer, then → IDLE.
  - magazine is sampled every cycle (it is not latched).
  - trig_rise during RELOAD is ignored: no fire, no fault.
- Mid-burst mode change out of attack, or ammo_count reaching 0, aborts the burst at cooldown exit with no fault.
- fire and loading_ammo are never high in the same cycle.
- All outputs are registered (Moore); fire is high in the cycle after the FSM enters FIRE. Trigger edge to fire latency is 2 cycles.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=0, FIRE=1, COOLDOWN=2, RELOAD=3 (2 bits);
  - MODE_ATTACK=4'b0010;
  - default BURST_LEN and RELOAD_CYCLES constants.
- One sub-module, fc_timer: 8-bit loadable down-counter with load, load value, dec and zero flag. It is shared by COOLDOWN and RELOAD, since those states are mutually exclusive.

Test Plan:
- Reset mid-reload: rst_n low during RELOAD → all outputs 0 in the same cycle, asynchronously; after release, state is IDLE and shots=0.
- Single shot: mode=0010, ammo_count=5, burst_en=0, cooldown=3, trigger held high 20 cycles → exactly one fire pulse, 2 cycles after the edge; shots=1; busy low 6 cycles after fire.
- Burst: burst_en=1, cooldown=2, ammo_count=10, one trigger edge → 3 fire pulses, 4 cycles apart; shots=3.
- Illegal triggers:
  - mode=0001 with a trigger edge → fault for 1 cycle, no fire.
  - mode=0010, ammo_count=0, trigger edge → fault for 1 cycle, no fire.
- Reload during burst: reload_req pulsed in the first COOLDOWN, magazine=300 → only 1 fire pulse; then loading_ammo high for 8 cycles with ammo_load=300; a trigger edge during those 8 cycles produces no fire and no fault.
- Saturation/limits: preload shots near max (SHOT_W=4 build, 20 shots) → shots stops at 15. With cooldown=0 in burst, fire pulses are every 2 cycles.
